// File: rtl/note_track_sequencer.sv
// note_track_sequencer: scrolls six note-track bitmaps once per frame, spawns notes at the top and judges key presses near the bottom.
module note_track_sequencer #(
    parameter int ROWS       = 480,
    parameter int NOTE_LEN   = 20,
    parameter int JUDGE_LINE = 440,
    parameter int JUDGE_WIN  = 16
) (
    input  logic            OriginalClk,
    input  logic            ResetN,
    input  logic            Running,
    input  logic            FrameTick,
    input  logic [3:0]      ScrollStep,
    input  logic            NoteValid,
    input  logic [5:0]      NoteMask,
    output logic            NoteReady,
    input  logic [5:0]      KeyPress,
    output logic [ROWS-1:0] track1_data,
    output logic [ROWS-1:0] track2_data,
    output logic [ROWS-1:0] track3_data,
    output logic [ROWS-1:0] track4_data,
    output logic [ROWS-1:0] track5_data,
    output logic [ROWS-1:0] track6_data,
    output logic [5:0]      HitPulse,
    output logic [5:0]      MissPulse,
    output logic            Busy
);
    typedef enum logic [1:0] {IDLE, SHIFT, JUDGE} state_t;

    localparam logic [ROWS-1:0] ONE      = ROWS'(1);
    localparam logic [ROWS-1:0] WIN_MASK = ((ONE << (2*JUDGE_WIN+1)) - ONE) << (JUDGE_LINE-JUDGE_WIN);
    localparam logic [ROWS-1:0] CLR_MASK = ~((ONE << (JUDGE_LINE-JUDGE_WIN-NOTE_LEN)) - ONE);

    state_t          state, state_nx;
    logic [3:0]      step;
    logic [ROWS-1:0] trk [6];
    logic [4:0]      cnt [6];
    logic [5:0]      last_fill, pend, key_q, key_rise, fill, hit;
    logic            start, spawn;

    assign start     = (state == IDLE) && Running && FrameTick;
    assign NoteReady = (state == IDLE) && Running && (fill == '0) && (last_fill == '0);
    assign spawn     = NoteValid && NoteReady;
    assign key_rise  = KeyPress & ~key_q;
    assign Busy      = (state != IDLE);

    assign track1_data = trk[0];
    assign track2_data = trk[1];
    assign track3_data = trk[2];
    assign track4_data = trk[3];
    assign track5_data = trk[4];
    assign track6_data = trk[5];

    always_comb begin
        fill = '0;
        hit  = '0;
        for (int i = 0; i < 6; i++) begin
            fill[i] = (cnt[i] != 5'd0);
            hit[i]  = pend[i] && |(trk[i] & WIN_MASK);
        end
    end

    always_comb begin
        state_nx = state;
        unique case (state)
            IDLE:    if (start) state_nx = (ScrollStep == 4'd0) ? JUDGE : SHIFT;
            SHIFT:   if (step == 4'd1) state_nx = JUDGE;
            JUDGE:   state_nx = IDLE;
            default: state_nx = IDLE;
        endcase
    end

    always_ff @(posedge OriginalClk or negedge ResetN) begin
        if (!ResetN) state <= IDLE;
        else         state <= state_nx;
    end

    always_ff @(posedge OriginalClk or negedge ResetN) begin
        if (!ResetN) begin
            step      <= '0;
            last_fill <= '0;
            pend      <= '0;
            key_q     <= '0;
            HitPulse  <= '0;
            MissPulse <= '0;
            for (int i = 0; i < 6; i++) begin
                trk[i] <= '0;
                cnt[i] <= '0;
            end
        end else begin
            key_q     <= KeyPress;
            HitPulse  <= '0;
            MissPulse <= '0;
            // a press landing in the judge cycle itself survives into the next frame
            pend      <= !Running ? '0 : (state == JUDGE) ? key_rise : (pend | key_rise);
            if (start) step <= ScrollStep;
            else if (state == SHIFT) step <= step - 4'd1;
            for (int i = 0; i < 6; i++) begin
                if (spawn && NoteMask[i]) cnt[i] <= 5'(NOTE_LEN);
                if (state == SHIFT) begin
                    trk[i]       <= {trk[i][ROWS-2:0], fill[i]};
                    last_fill[i] <= fill[i];
                    MissPulse[i] <= trk[i][ROWS-1] & ~trk[i][ROWS-2];
                    if (fill[i]) cnt[i] <= cnt[i] - 5'd1;
                end
                if (state == JUDGE && hit[i]) begin
                    HitPulse[i] <= 1'b1;
                    trk[i]      <= trk[i] & ~CLR_MASK;
                end
            end
        end
    end
endmodule

// File: tb/tb_note_track_sequencer.sv
// tb_note_track_sequencer: frame-level note-interval model checked against the sequencer.
module tb_note_track_sequencer;
    localparam int ROWS   = 480;
    localparam int NLEN   = 20;
    localparam int WIN_LO = 440 - 16;
    localparam int WIN_HI = 440 + 16;
    localparam int CLR_LO = 440 - 16 - 20;

    logic            clk = 0, rst_n = 0, running = 0, frame_tick = 0, note_valid = 0;
    logic            note_ready, busy;
    logic [3:0]      scroll_step = '0;
    logic [5:0]      note_mask = '0, key_press = '0, hit_pulse, miss_pulse;
    logic [ROWS-1:0] trk_o [6];
    int              n_cmp = 0, n_err = 0;

    // each note: total scroll when spawned, and how many of its bottom rows were cleared by a hit
    typedef struct {int s0; int jlo;} note_t;
    note_t      notes [6][$];
    int         scroll;
    int         last_s0 [6];
    logic [5:0] pend_m;

    note_track_sequencer dut (
        .OriginalClk(clk), .ResetN(rst_n), .Running(running), .FrameTick(frame_tick),
        .ScrollStep(scroll_step), .NoteValid(note_valid), .NoteMask(note_mask),
        .NoteReady(note_ready), .KeyPress(key_press),
        .track1_data(trk_o[0]), .track2_data(trk_o[1]), .track3_data(trk_o[2]),
        .track4_data(trk_o[3]), .track5_data(trk_o[4]), .track6_data(trk_o[5]),
        .HitPulse(hit_pulse), .MissPulse(miss_pulse), .Busy(busy)
    );

    always #5 clk = ~clk;

    function automatic void model_reset();
        scroll = 0;
        pend_m = '0;
        for (int i = 0; i < 6; i++) begin
            notes[i].delete();
            last_s0[i] = -1000;
        end
    endfunction

    function automatic bit model_ready();
        for (int i = 0; i < 6; i++) if (scroll - last_s0[i] < NLEN + 1) return 1'b0;
        return 1'b1;
    endfunction

    function automatic logic [ROWS-1:0] model_track(int t);
        logic [ROWS-1:0] v = '0;
        for (int n = 0; n < notes[t].size(); n++)
            for (int j = notes[t][n].jlo; j < NLEN; j++) begin
                int p = scroll - notes[t][n].s0 - 1 - j;
                if (p >= 0 && p < ROWS) v[p] = 1'b1;
            end
        return v;
    endfunction

    function automatic bit window_busy(int t);
        for (int n = 0; n < notes[t].size(); n++)
            for (int j = notes[t][n].jlo; j < NLEN; j++) begin
                int p = scroll - notes[t][n].s0 - 1 - j;
                if (p >= WIN_LO && p <= WIN_HI) return 1'b1;
            end
        return 1'b0;
    endfunction

    task automatic apply_reset();
        rst_n = 0; running = 0; frame_tick = 0; note_valid = 0; note_mask = '0; key_press = '0;
        @(negedge clk); @(negedge clk);
        rst_n = 1; running = 1;
        model_reset();
        @(negedge clk);
    endtask

    task automatic run_frame(input int step, input logic [5:0] offer, input logic [5:0] press,
                             input logic [5:0] jpress, input bit retick,
                             output logic [5:0] hits, output logic [5:0] misses);
        int miss_k [6];
        int sb, lo;
        bit rdy;
        logic [5:0] exp_hit, exp_m, exp_h;
        hits = '0; misses = '0;
        if (offer != '0) begin
            note_valid = 1; note_mask = offer; #1;
            rdy = model_ready();
            n_cmp++;
            if (note_ready !== rdy) begin
                n_err++; $display("FAIL note_ready_offer: got %b expected %b", note_ready, rdy);
            end
            @(negedge clk); note_valid = 0; note_mask = '0;
            if (rdy) for (int i = 0; i < 6; i++) if (offer[i]) begin
                notes[i].push_back('{scroll, 0}); last_s0[i] = scroll;
            end
        end
        if (press != '0) begin
            key_press = press; @(negedge clk); key_press = '0; @(negedge clk);
            pend_m |= press;
        end
        sb = scroll;
        for (int i = 0; i < 6; i++) begin
            miss_k[i] = 0;
            for (int n = 0; n < notes[i].size(); n++)
                if (notes[i][n].jlo < NLEN && sb - notes[i][n].s0 - NLEN < ROWS &&
                    sb + step - notes[i][n].s0 - NLEN >= ROWS)
                    miss_k[i] = ROWS + NLEN - sb + notes[i][n].s0 + 1;
        end
        scroll = sb + step;
        exp_hit = '0;
        for (int i = 0; i < 6; i++) begin
            if (pend_m[i] && window_busy(i)) begin
                exp_hit[i] = 1'b1;
                for (int n = 0; n < notes[i].size(); n++) begin
                    lo = scroll - notes[i][n].s0 - CLR_LO;
                    if (lo > notes[i][n].jlo) notes[i][n].jlo = lo;
                end
            end
            for (int n = notes[i].size() - 1; n >= 0; n--)
                if (notes[i][n].jlo >= NLEN || scroll - notes[i][n].s0 - NLEN >= ROWS) notes[i].delete(n);
        end
        pend_m = jpress;
        scroll_step = step[3:0]; frame_tick = 1;
        @(negedge clk); frame_tick = 0;
        for (int k = 1; k <= step + 3; k++) begin
            exp_m = '0;
            for (int i = 0; i < 6; i++) if (miss_k[i] == k) exp_m[i] = 1'b1;
            exp_h = (k == step + 2) ? exp_hit : '0;
            n_cmp++;
            if (miss_pulse !== exp_m) begin
                n_err++; $display("FAIL miss_pulse k=%0d: got %b expected %b", k, miss_pulse, exp_m);
            end
            n_cmp++;
            if (hit_pulse !== exp_h) begin
                n_err++; $display("FAIL hit_pulse k=%0d: got %b expected %b", k, hit_pulse, exp_h);
            end
            n_cmp++;
            if (busy !== (k <= step + 1)) begin
                n_err++; $display("FAIL busy k=%0d: got %b expected %b", k, busy, k <= step + 1);
            end
            hits |= hit_pulse; misses |= miss_pulse;
            if (retick) frame_tick = (k == 2);
            if (k == step + 1) key_press = jpress;
            if (k == step + 2) key_press = '0;
            if (k < step + 3) @(negedge clk);
        end
        n_cmp++;
        if (note_ready !== model_ready()) begin
            n_err++; $display("FAIL note_ready_idle: got %b expected %b", note_ready, model_ready());
        end
        for (int i = 0; i < 6; i++) begin
            n_cmp++;
            if (trk_o[i] !== model_track(i)) begin
                n_err++; $display("FAIL track%0d: got %h expected %h", i + 1, trk_o[i], model_track(i));
            end
        end
    endtask

    task automatic test_reset();
        logic [5:0] h, m;
        rst_n = 0; running = 0;
        @(negedge clk); @(negedge clk);
        n_cmp++; if (busy !== 1'b0) begin n_err++; $display("FAIL reset_busy: got %b expected 0", busy); end
        n_cmp++; if (note_ready !== 1'b0) begin n_err++; $display("FAIL reset_ready: got %b expected 0", note_ready); end
        n_cmp++; if (hit_pulse !== '0) begin n_err++; $display("FAIL reset_hit: got %b expected 0", hit_pulse); end
        n_cmp++; if (miss_pulse !== '0) begin n_err++; $display("FAIL reset_miss: got %b expected 0", miss_pulse); end
        for (int i = 0; i < 6; i++) begin
            n_cmp++;
            if (trk_o[i] !== '0) begin n_err++; $display("FAIL reset_track%0d: got %h expected 0", i + 1, trk_o[i]); end
        end
        rst_n = 1; running = 1; model_reset();
        @(negedge clk);
        n_cmp++; if (note_ready !== 1'b1) begin n_err++; $display("FAIL idle_ready: got %b expected 1", note_ready); end
        for (int f = 0; f < 3; f++) run_frame($urandom_range(0, 15), '0, '0, '0, 0, h, m);
    endtask

    task automatic test_spawn_miss();
        logic [5:0] h, m;
        logic [ROWS-1:0] e;
        apply_reset();
        run_frame(4, 6'b000001, '0, '0, 0, h, m);
        for (int f = 2; f <= 5; f++) run_frame(4, '0, '0, '0, 0, h, m);
        e = '0; e[19:0] = '1;
        n_cmp++; if (trk_o[0] !== e) begin n_err++; $display("FAIL spawn_f5: got %h expected %h", trk_o[0], e); end
        n_cmp++; if (note_ready !== 1'b0) begin n_err++; $display("FAIL gap_ready_f5: got %b expected 0", note_ready); end
        run_frame(4, '0, '0, '0, 0, h, m);
        e = '0; e[23:4] = '1;
        n_cmp++; if (trk_o[0] !== e) begin n_err++; $display("FAIL spawn_f6: got %h expected %h", trk_o[0], e); end
        n_cmp++; if (note_ready !== 1'b1) begin n_err++; $display("FAIL gap_ready_f6: got %b expected 1", note_ready); end
        for (int f = 7; f <= 124; f++) run_frame(4, '0, '0, '0, 0, h, m);
        e = '0; e[479:476] = '1;
        n_cmp++; if (trk_o[0] !== e) begin n_err++; $display("FAIL bottom_f124: got %h expected %h", trk_o[0], e); end
        run_frame(4, '0, '0, '0, 0, h, m);
        n_cmp++; if (m !== 6'b000001) begin n_err++; $display("FAIL miss_f125: got %b expected 000001", m); end
        n_cmp++; if (trk_o[0] !== '0) begin n_err++; $display("FAIL empty_f125: got %h expected 0", trk_o[0]); end
    endtask

    task automatic test_hit();
        logic [5:0] h, m, ms;
        apply_reset();
        run_frame(4, 6'b000001, '0, '0, 0, h, m);
        for (int f = 2; f <= 106; f++) run_frame(4, '0, '0, '0, 0, h, m);
        run_frame(4, '0, 6'b000001, '0, 0, h, m);
        n_cmp++; if (h !== 6'b000001) begin n_err++; $display("FAIL hit_f107: got %b expected 000001", h); end
        n_cmp++; if (trk_o[0] !== '0) begin n_err++; $display("FAIL hit_clear: got %h expected 0", trk_o[0]); end
        ms = '0;
        for (int f = 108; f <= 130; f++) begin run_frame(4, '0, '0, '0, 0, h, m); ms |= m; end
        n_cmp++; if (ms !== '0) begin n_err++; $display("FAIL no_miss_after_hit: got %b expected 0", ms); end
    endtask

    task automatic test_empty_and_judge_edge();
        logic [5:0] h, m;
        apply_reset();
        run_frame(4, 6'b000001, '0, '0, 0, h, m);
        for (int f = 2; f <= 104; f++) run_frame(4, '0, '0, '0, 0, h, m);
        run_frame(4, '0, 6'b000001, '0, 0, h, m);
        n_cmp++; if (h !== '0) begin n_err++; $display("FAIL empty_press: got %b expected 0", h); end
        run_frame(4, '0, '0, '0, 0, h, m);
        running = 0; key_press = 6'b000001;
        @(negedge clk); key_press = '0; frame_tick = 1;
        @(negedge clk); frame_tick = 0;
        n_cmp++; if (busy !== 1'b0) begin n_err++; $display("FAIL stopped_tick: got %b expected 0", busy); end
        n_cmp++; if (note_ready !== 1'b0) begin n_err++; $display("FAIL stopped_ready: got %b expected 0", note_ready); end
        @(negedge clk); running = 1;
        @(negedge clk);
        run_frame(4, '0, '0, 6'b000001, 0, h, m);
        n_cmp++; if (h !== '0) begin n_err++; $display("FAIL stale_pend: got %b expected 0", h); end
        run_frame(4, '0, '0, '0, 0, h, m);
        n_cmp++; if (h !== 6'b000001) begin n_err++; $display("FAIL judge_edge_hit: got %b expected 000001", h); end
    endtask

    task automatic test_busy_zero_reset();
        logic [5:0] h, m;
        apply_reset();
        run_frame(5, 6'h3f, '0, '0, 1, h, m);
        run_frame(0, '0, '0, '0, 0, h, m);
        run_frame(7, '0, '0, '0, 0, h, m);
        run_frame(7, '0, '0, '0, 0, h, m);
        scroll_step = 4'd10; frame_tick = 1;
        @(negedge clk); frame_tick = 0;
        @(negedge clk); @(negedge clk);
        n_cmp++; if (busy !== 1'b1) begin n_err++; $display("FAIL mid_shift_busy: got %b expected 1", busy); end
        rst_n = 0; #1;
        n_cmp++; if (busy !== 1'b0) begin n_err++; $display("FAIL abort_busy: got %b expected 0", busy); end
        for (int i = 0; i < 6; i++) begin
            n_cmp++;
            if (trk_o[i] !== '0) begin n_err++; $display("FAIL abort_track%0d: got %h expected 0", i + 1, trk_o[i]); end
        end
        @(negedge clk); rst_n = 1; model_reset();
        @(negedge clk);
        run_frame(3, '0, '0, '0, 0, h, m);
    endtask

    task automatic test_random();
        logic [5:0] h, m;
        int st;
        apply_reset();
        for (int f = 0; f < 300; f++) begin
            st = $urandom_range(0, 15);
            run_frame(st,
                      ($urandom_range(0, 2) == 0) ? 6'($urandom) : 6'b0,
                      6'($urandom & $urandom),
                      ($urandom_range(0, 4) == 0) ? 6'($urandom & $urandom) : 6'b0,
                      (st >= 2) && ($urandom_range(0, 3) == 0), h, m);
        end
    endtask

    initial begin
        test_reset();
        test_spawn_miss();
        test_hit();
        test_empty_and_judge_edge();
        test_busy_zero_reset();
        test_random();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end
endmodule
